// File: rtl/student_iis_fir_scheduler.sv
// student_iis_fir_scheduler
// Shares one FIR engine between the left and right audio channels. A stereo
// pair is captured on the receiver strobe, sent to the FIR as left then right,
// and both results go to the transmitter together on a single valid strobe.
// A new pair arriving while the buffer is still full raises the sticky
// overrun flag. A FIR that never answers raises the sticky timeout flag, and
// the missing result is muted.
// Optional feature: define STUDENT_IIS_FIR_SCHED_BYPASS_EN to add bypass_i.
// A bypassed frame skips the FIR and publishes the resized receiver samples.

module student_iis_fir_scheduler #(
  parameter int DATA_SIZE         = 16,
  parameter int DATA_SIZE_FIR_OUT = 16,
  parameter int TIMEOUT_CYCLES    = 1024
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
`ifdef STUDENT_IIS_FIR_SCHED_BYPASS_EN
  input  logic                         bypass_i,
`endif
  input  logic [DATA_SIZE-1:0]         rx_data_l_i,
  input  logic [DATA_SIZE-1:0]         rx_data_r_i,
  input  logic                         rx_valid_i,
  output logic [DATA_SIZE-1:0]         fir_in_data_o,
  output logic                         fir_in_chan_o,
  output logic                         fir_in_valid_o,
  input  logic                         fir_in_ready_i,
  input  logic [DATA_SIZE_FIR_OUT-1:0] fir_out_data_i,
  input  logic                         fir_out_valid_i,
  output logic [DATA_SIZE_FIR_OUT-1:0] tx_data_l_o,
  output logic [DATA_SIZE_FIR_OUT-1:0] tx_data_r_o,
  output logic                         tx_valid_o,
  output logic                         busy_o,
  input  logic                         clr_flags_i,
  output logic                         overrun_o,
  output logic                         timeout_o
);

  // The counter only has to reach TIMEOUT_CYCLES-1.
  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE_L = 3'd1,
    WAIT_L  = 3'd2,
    ISSUE_R = 3'd3,
    WAIT_R  = 3'd4,
    PUBLISH = 3'd5
  } state_t;

  state_t state_reg, state_next;

  // Channel index 0 is left and 1 is right, matching fir_in_chan_o.
  logic                                pend_full_reg;
  logic [1:0][DATA_SIZE-1:0]           pend_reg;
  logic [1:0][DATA_SIZE-1:0]           work_reg;
  logic [1:0][DATA_SIZE_FIR_OUT-1:0]   res_reg;
  logic [CNT_W-1:0]                    cnt_reg, cnt_next;
  logic [DATA_SIZE_FIR_OUT-1:0]        tx_l_reg, tx_r_reg;
  logic                                tx_valid_reg;
  logic                                overrun_reg, timeout_reg;

  logic start_frame;
  logic take_bypass;
  logic in_wait;
  logic cnt_expired;
  logic wait_done;
  logic overrun_set;
  logic timeout_set;

  // A frame starts when the FSM is idle and a captured pair is waiting.
  assign start_frame = (state_reg == IDLE) && pend_full_reg;
  assign in_wait     = (state_reg == WAIT_L) || (state_reg == WAIT_R);
  assign cnt_expired = (cnt_reg == CNT_LAST);
  // A result arriving in the expiry cycle still counts as a normal result.
  assign wait_done   = in_wait && (fir_out_valid_i || cnt_expired);
  assign timeout_set = in_wait && cnt_expired && !fir_out_valid_i;
  // Overwriting a pair that is not consumed in the same cycle drops it.
  assign overrun_set = rx_valid_i && pend_full_reg && !start_frame;
  // The counter runs only while waiting and restarts from 0 for each channel.
  assign cnt_next    = (in_wait && !wait_done) ? cnt_reg + CNT_W'(1) : '0;

`ifdef STUDENT_IIS_FIR_SCHED_BYPASS_EN
  // bypass_i is sampled only when a frame starts, so changing it mid-frame
  // takes effect on the next frame.
  assign take_bypass = start_frame && bypass_i;
`else
  assign take_bypass = 1'b0;
`endif

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic: left then right through the FIR, then publish
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (start_frame) begin
          state_next = take_bypass ? PUBLISH : ISSUE_L;
        end
      end
      ISSUE_L: begin
        if (fir_in_ready_i) begin
          state_next = WAIT_L;
        end
      end
      WAIT_L: begin
        if (wait_done) begin
          state_next = ISSUE_R;
        end
      end
      ISSUE_R: begin
        if (fir_in_ready_i) begin
          state_next = WAIT_R;
        end
      end
      WAIT_R: begin
        if (wait_done) begin
          state_next = PUBLISH;
        end
      end
      PUBLISH: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // FSM outputs: FIR request side and busy indication
  always_comb begin
    fir_in_valid_o = 1'b0;
    fir_in_chan_o  = 1'b0;
    fir_in_data_o  = '0;
    busy_o         = (state_reg != IDLE);
    case (state_reg)
      ISSUE_L: begin
        fir_in_valid_o = 1'b1;
        fir_in_chan_o  = 1'b0;
        fir_in_data_o  = work_reg[0];
      end
      ISSUE_R: begin
        fir_in_valid_o = 1'b1;
        fir_in_chan_o  = 1'b1;
        fir_in_data_o  = work_reg[1];
      end
      default: begin
      end
    endcase
  end

  // One-entry pending buffer: a new strobe always loads, and starting a frame empties it
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_full_reg <= 1'b0;
      pend_reg      <= '0;
    end else if (rx_valid_i) begin
      pend_full_reg <= 1'b1;
      pend_reg[0]   <= rx_data_l_i;
      pend_reg[1]   <= rx_data_r_i;
    end else if (start_frame) begin
      pend_full_reg <= 1'b0;
    end
  end

  // Working copy of the frame being processed, so the buffer can refill meanwhile
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      work_reg <= '0;
    end else if (start_frame) begin
      work_reg <= pend_reg;
    end
  end

  // Result timeout counter
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  // Per-channel result registers: FIR result, muted zero on timeout, or bypass sample
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_chan
      localparam state_t WAIT_ST = (gi == 0) ? WAIT_L : WAIT_R;
      logic [DATA_SIZE_FIR_OUT-1:0] byp_val;

`ifdef STUDENT_IIS_FIR_SCHED_BYPASS_EN
      if (DATA_SIZE_FIR_OUT >= DATA_SIZE) begin : g_sext
        assign byp_val = DATA_SIZE_FIR_OUT'($signed(pend_reg[gi]));
      end else begin : g_trunc
        assign byp_val = pend_reg[gi][DATA_SIZE-1 -: DATA_SIZE_FIR_OUT];
      end
`else
      assign byp_val = '0;
`endif

      // Latch this channel's result when its wait ends
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          res_reg[gi] <= '0;
        end else if (take_bypass) begin
          res_reg[gi] <= byp_val;
        end else if ((state_reg == WAIT_ST) && wait_done) begin
          res_reg[gi] <= fir_out_valid_i ? fir_out_data_i : '0;
        end
      end
    end
  endgenerate

  // Transmitter outputs: both channels update together with a one-cycle strobe
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tx_l_reg     <= '0;
      tx_r_reg     <= '0;
      tx_valid_reg <= 1'b0;
    end else begin
      tx_valid_reg <= (state_reg == PUBLISH);
      if (state_reg == PUBLISH) begin
        tx_l_reg <= res_reg[0];
        tx_r_reg <= res_reg[1];
      end
    end
  end

  // Sticky flags: setting has priority over clearing
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      overrun_reg <= 1'b0;
      timeout_reg <= 1'b0;
    end else begin
      if (overrun_set) begin
        overrun_reg <= 1'b1;
      end else if (clr_flags_i) begin
        overrun_reg <= 1'b0;
      end
      if (timeout_set) begin
        timeout_reg <= 1'b1;
      end else if (clr_flags_i) begin
        timeout_reg <= 1'b0;
      end
    end
  end

  assign tx_data_l_o = tx_l_reg;
  assign tx_data_r_o = tx_r_reg;
  assign tx_valid_o  = tx_valid_reg;
  assign overrun_o   = overrun_reg;
  assign timeout_o   = timeout_reg;

endmodule
